// File: rtl/qr_mult_pkg.sv
// -----------------------------------------------------------------------------
// qr_mult_pkg
//   Shared definitions for the QR-decomposition multiplier sharing logic.
//   Holds the canonical operand/product widths, the pipeline depth of the
//   shared multiplier, the request/response record types and the product
//   helper used by the multiplier pipeline.
// -----------------------------------------------------------------------------
package qr_mult_pkg;

  localparam int MULT_A_W  = 16;                    // operand A width
  localparam int MULT_B_W  = 16;                    // operand B width
  localparam int MULT_LAT  = 2;                     // multiplier stages
  localparam int MULT_P_W  = MULT_A_W + MULT_B_W;   // full product width
  localparam int MULT_ID_W = 3;                     // tag width, covers up to 8 requesters

  typedef struct packed {
    logic [MULT_A_W-1:0]  a;
    logic [MULT_B_W-1:0]  b;
    logic                 tc;
    logic [MULT_ID_W-1:0] id;
  } mult_req_t;

  typedef struct packed {
    logic [MULT_P_W-1:0]  prod;
    logic                 valid;
    logic [MULT_ID_W-1:0] id;
  } mult_rsp_t;

  // Both operands are extended to the full product width (sign-extended when
  // tc=1, zero-extended otherwise). The low MULT_P_W bits of the product of
  // the extended operands are then the exact signed or unsigned result.
  function automatic logic [MULT_P_W-1:0] mult_product(
    input logic [MULT_A_W-1:0] a,
    input logic [MULT_B_W-1:0] b,
    input logic                tc
  );
    logic [MULT_P_W-1:0] a_ext;
    logic [MULT_P_W-1:0] b_ext;
    a_ext = {{MULT_B_W{tc & a[MULT_A_W-1]}}, a};
    b_ext = {{MULT_A_W{tc & b[MULT_B_W-1]}}, b};
    return a_ext * b_ext;
  endfunction

endpackage

// File: rtl/mult_pipe_tagged.sv
// -----------------------------------------------------------------------------
// mult_pipe_tagged
//   Pipelined 16x16 multiplier (MULT_LAT stages) with the valid flag and
//   requester tag carried alongside the product. Stage 0 is the internal
//   multiplier register, the last stage is the registered output.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_v              operation valid
//   i_a, i_b, i_tc   operands and mode (1 = two's complement, 0 = unsigned)
//   i_id             requester tag
//   o_mul_v          valid of the internal multiplier register
//   o_prod           product (registered)
//   o_prod_valid     product valid, one cycle per accepted operation
//   o_prod_id        tag of o_prod
// -----------------------------------------------------------------------------
module mult_pipe_tagged
  import qr_mult_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_v,
  input  logic [MULT_A_W-1:0]  i_a,
  input  logic [MULT_B_W-1:0]  i_b,
  input  logic                 i_tc,
  input  logic [MULT_ID_W-1:0] i_id,
  output logic                 o_mul_v,
  output logic [MULT_P_W-1:0]  o_prod,
  output logic                 o_prod_valid,
  output logic [MULT_ID_W-1:0] o_prod_id
);

  mult_rsp_t stage_reg [MULT_LAT];

  // Reset clears every stage, so in-flight results are dropped on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MULT_LAT; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0].prod  <= mult_product(i_a, i_b, i_tc);
      stage_reg[0].valid <= i_v;
      stage_reg[0].id    <= i_id;
      for (int i = 1; i < MULT_LAT; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign o_mul_v      = stage_reg[0].valid;
  assign o_prod       = stage_reg[MULT_LAT-1].prod;
  assign o_prod_valid = stage_reg[MULT_LAT-1].valid;
  assign o_prod_id    = stage_reg[MULT_LAT-1].id;

endmodule

// File: rtl/mult_share_arb.sv
// -----------------------------------------------------------------------------
// mult_share_arb
//   Round-robin arbiter that time-shares one pipelined multiplier among N_REQ
//   requesters. One operation is accepted per cycle; results are broadcast
//   with their requester tag three cycles after the grant.
//
// Build option
//   MULT_ARB_PRIO0_EN  when defined, requester 0 has absolute priority and its
//                      grants leave the round-robin pointer untouched; the
//                      remaining requesters share round-robin.
//
// Parameters
//   N_REQ (2..8), A_WIDTH, B_WIDTH (must match the qr_mult_pkg widths, which
//   size the shared datapath), ID_W = $clog2(N_REQ) (derived)
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req            per-requester request, held until granted
//   i_a, i_b         packed operands, requester k at [k*W +: W]
//   i_tc             per-requester mode (1 = two's complement)
//   o_gnt            one-hot combinational grant
//   o_prod           product, o_prod_valid pulse, o_prod_id tag
//   o_busy           request pending or operation in flight
// -----------------------------------------------------------------------------
module mult_share_arb
  import qr_mult_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int A_WIDTH = 16,
  parameter  int B_WIDTH = 16,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*A_WIDTH-1:0]   i_a,
  input  logic [N_REQ*B_WIDTH-1:0]   i_b,
  input  logic [N_REQ-1:0]           i_tc,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [A_WIDTH+B_WIDTH-1:0] o_prod,
  output logic                       o_prod_valid,
  output logic [ID_W-1:0]            o_prod_id,
  output logic                       o_busy
);

  logic [ID_W-1:0]      rr_ptr_reg;
  logic [ID_W-1:0]      rr_ptr_next;
  logic [N_REQ-1:0]     rr_req;
  logic [ID_W-1:0]      rr_cand;
  logic [ID_W-1:0]      rr_idx;
  logic                 rr_any;
  logic [ID_W-1:0]      gnt_idx;
  logic                 gnt_any;
  logic                 ptr_adv;
  logic [A_WIDTH-1:0]   sel_a;
  logic [B_WIDTH-1:0]   sel_b;
  mult_req_t            iss_req_reg;
  logic                 iss_v_reg;
  logic                 mul_v;
  logic [MULT_ID_W-1:0] pipe_id;
  logic                 unused_id_bits;

`ifdef MULT_ARB_PRIO0_EN
  // Requester 0 is served outside the rotation.
  assign rr_req = {i_req[N_REQ-1:1], 1'b0};
`else
  assign rr_req = i_req;
`endif

  // Scan from the farthest candidate to the nearest so the last hit is the
  // first asserted requester at or after the pointer.
  always_comb begin
    rr_cand = '0;
    rr_idx  = '0;
    rr_any  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      rr_cand = ID_W'((int'(rr_ptr_reg) + i) % N_REQ);
      if (rr_req[rr_cand]) begin
        rr_idx = rr_cand;
        rr_any = 1'b1;
      end
    end
  end

`ifdef MULT_ARB_PRIO0_EN
  assign gnt_any = i_req[0] | rr_any;
  assign gnt_idx = i_req[0] ? '0 : rr_idx;
  assign ptr_adv = rr_any & ~i_req[0];
`else
  assign gnt_any = rr_any;
  assign gnt_idx = rr_idx;
  assign ptr_adv = rr_any;
`endif

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (ptr_adv) begin
      rr_ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  // Grant is masked during reset so nothing upstream sees an acceptance.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
    assign o_gnt[gi] = i_rst_n & gnt_any & (gnt_idx == ID_W'(gi));
  end

  always_comb begin
    sel_a = i_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
    sel_b = i_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
  end

  // Operand fields only load on a grant; when iss_v_reg is low they are stale
  // and ignored downstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_reg  <= '0;
      iss_v_reg   <= 1'b0;
      iss_req_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      iss_v_reg  <= gnt_any;
      if (gnt_any) begin
        iss_req_reg.a  <= sel_a;
        iss_req_reg.b  <= sel_b;
        iss_req_reg.tc <= i_tc[gnt_idx];
        iss_req_reg.id <= MULT_ID_W'(gnt_idx);
      end
    end
  end

  mult_pipe_tagged u_pipe (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_v          (iss_v_reg),
    .i_a          (iss_req_reg.a),
    .i_b          (iss_req_reg.b),
    .i_tc         (iss_req_reg.tc),
    .i_id         (iss_req_reg.id),
    .o_mul_v      (mul_v),
    .o_prod       (o_prod),
    .o_prod_valid (o_prod_valid),
    .o_prod_id    (pipe_id)
  );

  // The tag travels at package width; only the low ID_W bits are meaningful.
  assign o_prod_id      = pipe_id[ID_W-1:0];
  assign unused_id_bits = ^pipe_id;

  assign o_busy = (|i_req) | iss_v_reg | mul_v | o_prod_valid;

endmodule

// File: tb/tb_mult_share_arb.sv
`timescale 1ns/1ps
module tb_mult_share_arb;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req   = '0;
  logic [63:0] a_bus = '0;
  logic [63:0] b_bus = '0;
  logic [3:0]  tc_bus = '0;
  logic [3:0]  gnt;
  logic [31:0] prod;
  logic        prod_valid;
  logic [1:0]  prod_id;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed products for the fixed per-requester operands:
  //   r0: 0x0002 * 0x0003 unsigned      = 0x00000006
  //   r1: 0xFFFF * 0xFFFF unsigned      = 0xFFFE0001
  //   r2: -3 * 5 signed                 = 0xFFFFFFF1
  //   r3: -32768 * 32767 signed         = 0xC0008000
  logic [31:0] prod_tab [4];

  // Expected result delay line: entry 2 is what the outputs must show now.
  logic        exp_v  [3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] exp_p  [3] = '{32'd0, 32'd0, 32'd0};
  logic [1:0]  exp_id [3] = '{2'd0, 2'd0, 2'd0};
  logic        cur_v  = 1'b0;
  logic [31:0] cur_p  = '0;
  logic [1:0]  cur_id = '0;

  always #5 clk = ~clk;

  mult_share_arb dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_a          (a_bus),
    .i_b          (b_bus),
    .i_tc         (tc_bus),
    .o_gnt        (gnt),
    .o_prod       (prod),
    .o_prod_valid (prod_valid),
    .o_prod_id    (prod_id),
    .o_busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_v[i]  <= 1'b0;
        exp_p[i]  <= '0;
        exp_id[i] <= '0;
      end
    end else begin
      exp_v[0]  <= cur_v;
      exp_p[0]  <= cur_p;
      exp_id[0] <= cur_id;
      for (int i = 1; i < 3; i++) begin
        exp_v[i]  <= exp_v[i-1];
        exp_p[i]  <= exp_p[i-1];
        exp_id[i] <= exp_id[i-1];
      end
    end
  end

  always @(negedge clk) begin
    check("prod_valid", 32'(prod_valid), 32'(exp_v[2]));
    if (exp_v[2]) begin
      check("prod", prod, exp_p[2]);
      check("prod_id", 32'(prod_id), 32'(exp_id[2]));
      $display("result id=%0d prod=%h", prod_id, prod);
    end
  end

  // One cycle: drive requests, check the combinational grant, record what
  // the grant must produce three cycles later.
  task automatic cycle(input logic [3:0] r, input logic [3:0] eg, input string tag);
    @(negedge clk);
    req = r;
    #1;
    check(tag, 32'(gnt), 32'(eg));
    if (r != 4'b0) check("busy_req", 32'(busy), 32'd1);
    cur_v  = |eg;
    cur_id = '0;
    cur_p  = '0;
    for (int k = 0; k < 4; k++) begin
      if (eg[k]) begin
        cur_id = 2'(k);
        cur_p  = prod_tab[k];
      end
    end
    $display("cycle %s req=%b gnt=%b", tag, r, gnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000, 4'b0000, "idle");
  endtask

  initial begin
    prod_tab[0] = 32'h0000_0006;
    prod_tab[1] = 32'hFFFE_0001;
    prod_tab[2] = 32'hFFFF_FFF1;
    prod_tab[3] = 32'hC000_8000;
    a_bus  = {16'h8000, 16'hFFFD, 16'hFFFF, 16'h0002};
    b_bus  = {16'h7FFF, 16'h0005, 16'hFFFF, 16'h0003};
    tc_bus = 4'b1100;

    // Reset: outputs zero, grant forced low even with requests present.
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_prod", prod, 32'd0);
    check("rst_valid", 32'(prod_valid), 32'd0);
    check("rst_id", 32'(prod_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("idle_busy", 32'(busy), 32'd0);

`ifndef MULT_ARB_PRIO0_EN
    // All four requesting: 0,1,2,3,0,1 with results back to back.
    cycle(4'b1111, 4'b0001, "all_0");
    cycle(4'b1111, 4'b0010, "all_1");
    cycle(4'b1111, 4'b0100, "all_2");
    cycle(4'b1111, 4'b1000, "all_3");
    cycle(4'b1111, 4'b0001, "all_4");
    cycle(4'b1111, 4'b0010, "all_5");
    idle(4);
    check("quiet_busy", 32'(busy), 32'd0);

    // Unsigned 0xFFFF*0xFFFF from requester 1 (pointer at 2).
    cycle(4'b0010, 4'b0010, "unsigned_r1");
    idle(4);

    // Signed -3*5 from requester 2, then wrap: pointer at 3, only req0.
    cycle(4'b0100, 4'b0100, "signed_r2");
    cycle(4'b0001, 4'b0001, "wrap_r0");
    cycle(4'b1010, 4'b0010, "after_wrap");
    cycle(4'b1000, 4'b1000, "grant_r3");
    cycle(4'b0001, 4'b0001, "r0_after_r3");
    cycle(4'b1010, 4'b0010, "r1_over_r3");
    // Sustained single requester gets every cycle.
    cycle(4'b0010, 4'b0010, "hold_r1_a");
    cycle(4'b0010, 4'b0010, "hold_r1_b");
    cycle(4'b0010, 4'b0010, "hold_r1_c");
    cycle(4'b0101, 4'b0100, "rr_r2");
    cycle(4'b0101, 4'b0001, "rr_r0");
    idle(4);
    check("quiet_busy2", 32'(busy), 32'd0);
`else
    // Requester 0 starves requester 1 while held.
    cycle(4'b0011, 4'b0001, "prio_a");
    cycle(4'b0011, 4'b0001, "prio_b");
    cycle(4'b0011, 4'b0001, "prio_c");
    cycle(4'b0010, 4'b0010, "prio_drop0");
    cycle(4'b0111, 4'b0001, "prio_d");
    cycle(4'b0110, 4'b0100, "prio_rr");
    idle(4);
    check("quiet_busy2", 32'(busy), 32'd0);
`endif

    // Reset one cycle after a grant: the result must never appear.
    cycle(4'b0100, 4'b0100, "pre_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    cur_v = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_prod", prod, 32'd0);
    check("midrst_valid", 32'(prod_valid), 32'd0);
    check("midrst_id", 32'(prod_id), 32'd0);
    @(negedge clk);
    #2;
    req   = 4'b0000;
    rst_n = 1'b1;
    idle(5);
    // Arbitration restarts from requester 0.
    cycle(4'b1111, 4'b0001, "post_rst_0");
    cycle(4'b1111, 4'b0010, "post_rst_1");
    idle(4);
    check("quiet_busy3", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
